ram_bist: RTL and testbench



---
 rtl/ram_bist.sv | 145 ++++++++++++++
 tb/tb_ram_bist.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ram_bist.sv
// March BIST controller for a single-port synchronous RAM. It runs three march
// elements (write P up; read P/write ~P up; read ~P/write P down) and stops at the first miscompare.
module ram_bist #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    DATA_WIDTH = 8,
  parameter logic [DATA_WIDTH-1:0] PATTERN    = 8'h55
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_expected,
  output logic [DATA_WIDTH-1:0] fail_actual,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state  | meaning
  // IDLE   | waiting for start, RAM port quiet
  // M0_W   | write P, ascending
  // M1_R   | issue read, ascending
  // M1_CW  | compare with P, write ~P
  // M2_R   | issue read, descending
  // M2_CW  | compare with ~P, write P
  // FINISH | one-cycle done pulse
  typedef enum logic [2:0] {
    S_IDLE, S_M0_W, S_M1_R, S_M1_CW, S_M2_R, S_M2_CW, S_FINISH
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX  = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DATA_WIDTH-1:0] PAT_INV   = ~PATTERN;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    pass_q, pass_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d;
  logic [DATA_WIDTH-1:0]   fail_expected_q, fail_expected_d;
  logic [DATA_WIDTH-1:0]   fail_actual_q, fail_actual_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      pass_q          <= 1'b0;
      fail_addr_q     <= '0;
      fail_expected_q <= '0;
      fail_actual_q   <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      pass_q          <= pass_d;
      fail_addr_q     <= fail_addr_d;
      fail_expected_q <= fail_expected_d;
      fail_actual_q   <= fail_actual_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    pass_d          = pass_q;
    fail_addr_d     = fail_addr_q;
    fail_expected_d = fail_expected_q;
    fail_actual_d   = fail_actual_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pass_d          = 1'b0;
          fail_addr_d     = '0;
          fail_expected_d = '0;
          fail_actual_d   = '0;
          addr_d          = '0;
          state_d         = S_M0_W;
        end
      end
      S_M0_W: begin
        if (addr_q == ADDR_MAX) begin
          addr_d  = '0;
          state_d = S_M1_R;
        end else begin
          addr_d = addr_q + ADDR_ONE;
        end
      end
      S_M1_R: state_d = S_M1_CW;
      S_M1_CW: begin
        if (mem_rdata != PATTERN) begin
          fail_addr_d     = addr_q;
          fail_expected_d = PATTERN;
          fail_actual_d   = mem_rdata;
          state_d         = S_FINISH;
        end else if (addr_q == ADDR_MAX) begin
          state_d = S_M2_R;
        end else begin
          addr_d  = addr_q + ADDR_ONE;
          state_d = S_M1_R;
        end
      end
      S_M2_R: state_d = S_M2_CW;
      S_M2_CW: begin
        if (mem_rdata != PAT_INV) begin
          fail_addr_d     = addr_q;
          fail_expected_d = PAT_INV;
          fail_actual_d   = mem_rdata;
          state_d         = S_FINISH;
        end else if (addr_q == ADDR_ZERO) begin
          pass_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          addr_d  = addr_q - ADDR_ONE;
          state_d = S_M2_R;
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // RAM port is decoded from registered state only; mem_rdata never reaches it
  always_comb begin
    mem_we    = 1'b0;
    mem_wdata = '0;
    case (state_q)
      S_M0_W:  begin mem_we = 1'b1; mem_wdata = PATTERN; end
      S_M1_CW: begin mem_we = 1'b1; mem_wdata = PAT_INV; end
      S_M2_CW: begin mem_we = 1'b1; mem_wdata = PATTERN; end
      default: ;
    endcase
  end

  assign mem_addr      = addr_q;
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FINISH);
  assign pass          = pass_q;
  assign fail_addr     = fail_addr_q;
  assign fail_expected = fail_expected_q;
  assign fail_actual   = fail_actual_q;

endmodule

// File: tb/tb_ram_bist.sv
// Bench for ram_bist: a 1 KB RAM model with an optional stuck-at bit, and an
// array-based march reference that predicts done cycle, verdict and failure data.
module tb_ram_bist;
  localparam logic [7:0] P  = 8'h55;
  localparam logic [7:0] NP = 8'hAA;

  logic       clk = 1'b0;
  logic       reset, start;
  logic       busy, done, pass, mem_we;
  logic [9:0] fail_addr, mem_addr;
  logic [7:0] fail_expected, fail_actual, mem_wdata, mem_rdata;

  logic [7:0] ram [0:1023];
  bit         f_en;
  int         f_addr, f_bit;
  bit         f_val;
  int         n_chk = 0;
  int         n_pass = 0;

  ram_bist #(.ADDR_WIDTH(10), .DATA_WIDTH(8), .PATTERN(8'h55)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_expected(fail_expected), .fail_actual(fail_actual),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] apply_flt(input int a, input logic [7:0] d);
    logic [7:0] r;
    r = d;
    if (f_en && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= apply_flt(int'(mem_addr), mem_wdata);
    else        mem_rdata     <= ram[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Plays the march over an array holding the faulty cell behaviour.
  task automatic model_run(output int e_done, output bit e_pass, output int e_fa,
                           output int e_fe, output int e_fx, output int e_we);
    logic [7:0] m [0:1023];
    bit hit;
    hit = 0; e_pass = 0; e_fa = 0; e_fe = 0; e_fx = 0; e_we = 0; e_done = 0;
    for (int a = 0; a < 1024; a++) begin m[a] = apply_flt(a, P); e_we++; end
    for (int a = 0; a < 1024 && !hit; a++) begin
      e_we++;
      if (m[a] != P) begin
        hit = 1; e_fa = a; e_fe = P; e_fx = m[a]; e_done = 1027 + 2*a;
      end else m[a] = apply_flt(a, NP);
    end
    for (int a = 1023; a >= 0 && !hit; a--) begin
      e_we++;
      if (m[a] != NP) begin
        hit = 1; e_fa = a; e_fe = NP; e_fx = m[a]; e_done = 3073 + 2*(1023 - a) + 2;
      end else m[a] = apply_flt(a, P);
    end
    if (!hit) begin e_pass = 1; e_done = 5121; end
  endtask

  // Caller is positioned 1 time unit after a rising edge with the DUT idle.
  task automatic do_run(input bit repulse, input int reset_at);
    int e_done, e_fa, e_fe, e_fx, e_we;
    bit e_pass, seen;
    int done_k, done_cnt, we_cnt, busy_cnt, bad;
    logic       o_pass;
    logic [9:0] o_fa;
    logic [7:0] o_fe, o_fx;
    model_run(e_done, e_pass, e_fa, e_fe, e_fx, e_we);
    seen = 0; done_k = 0; done_cnt = 0; we_cnt = 0; busy_cnt = 0;
    o_pass = 0; o_fa = 0; o_fe = 0; o_fx = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 6000; k++) begin
      if (mem_we) we_cnt++;
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (!seen) begin
          seen = 1; done_k = k; o_pass = pass; o_fa = fail_addr; o_fe = fail_expected; o_fx = fail_actual;
        end
        if (repulse) start = 1'b1;
      end
      if (reset_at > 0 && k == reset_at) begin
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_busy", busy, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_pass", pass, 0);
        chk("rst_addr", mem_addr, 0);
        reset = 1'b0;
        return;
      end
      if (repulse && k == 500) start = 1'b1;
      if (repulse && k == 501) start = 1'b0;
      if (seen && k == done_k + 1) begin
        start = 1'b0;
        chk("idle_after", busy, 0);
        chk("pass_hold", pass, e_pass);
      end
      if (seen && k == done_k + 3) break;
      @(posedge clk); #1;
    end
    chk("done_seen", seen, 1);
    chk("done_cycle", done_k, e_done);
    chk("done_count", done_cnt, 1);
    chk("pass", o_pass, e_pass);
    chk("fail_addr", o_fa, e_fa);
    chk("fail_expected", o_fe, e_fe);
    chk("fail_actual", o_fx, e_fx);
    chk("we_cycles", we_cnt, e_we);
    chk("busy_cycles", busy_cnt, e_done);
    if (e_pass) begin
      bad = 0;
      for (int a = 0; a < 1024; a++) if (ram[a] !== P) bad++;
      chk("ram_final", bad, 0);
    end
  endtask

  task automatic set_fault(input bit en, input int a, input int b, input bit v);
    f_en = en; f_addr = a; f_bit = b; f_val = v;
  endtask

  initial begin
    int we_seen, nz;
    reset = 1'b1; start = 1'b0;
    set_fault(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    we_seen = 0; nz = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_we) we_seen++;
      if (busy || done || pass || fail_addr != 0 || fail_expected != 0 || fail_actual != 0
          || mem_addr != 0 || mem_wdata != 0) nz++;
      @(posedge clk); #1;
    end
    chk("idle_we", we_seen, 0);
    chk("idle_outputs", nz, 0);

    do_run(1, 0);                                  // clean run with ignored start pulses
    set_fault(1, 10'h2A3, 0, 0); do_run(0, 0);     // stuck-at-0, caught in M1
    set_fault(1, 10'h000, 0, 1); do_run(0, 0);     // stuck-at-1, caught in M2 at the last address
    set_fault(0, 0, 0, 0);
    do_run(0, 2000);
    do_run(0, 0);

    for (int r = 0; r < 6; r++) begin
      repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
      set_fault($urandom_range(0, 3) != 0, $urandom_range(0, 1023), $urandom_range(0, 7),
                $urandom_range(0, 1) == 1);
      do_run(0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
